huffman_param: RTL and testbench

//  Parametrised Huffman encoder. Builds a per-frame symbol histogram and a Huffman tree, then publishes the per-symbol code and mask.
//  - Symbol count, count width and code width are parameters; zero-count symbols are excluded from the tree.
//  - Frames are delimited by gray_last; frame acceptance and result hand-off are handshaked.
//  - Sits after the grey-level quantiser, ahead of the bitstream packer.

---
 rtl/huffman_pkg.sv | 24 ++
 rtl/huffman_min2_scan.sv | 60 ++++++
 rtl/huffman_param.sv | 245 ++++++++++++++++++++++++
 tb/tb_huffman_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared types and constants for the Huffman encoder
package huffman_pkg;

    // Slot index width: 2*NSYM-1 tree slots fit in 5 bits for NSYM up to 15.
    localparam int SLOT_W = 5;
    typedef logic [SLOT_W-1:0] slot_t;

    // All-ones slot never addresses a real node; marks "no parent" / "no candidate".
    localparam slot_t NIL_SLOT = '1;

    // FSM encoding
    localparam logic [2:0] ST_COLLECT = 3'd0;
    localparam logic [2:0] ST_HIST    = 3'd1;
    localparam logic [2:0] ST_SCAN    = 3'd2;
    localparam logic [2:0] ST_MERGE   = 3'd3;
    localparam logic [2:0] ST_WALK    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // err bit positions
    localparam int ERR_BAD_SYM  = 0;
    localparam int ERR_CNT_SAT  = 1;
    localparam int ERR_CODE_OVF = 2;

endpackage

// File: rtl/huffman_min2_scan.sv
// rtl/huffman_min2_scan.sv - serial two-smallest search over tree slots
module huffman_min2_scan
    import huffman_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          step,
    input  slot_t         cand_idx,
    input  logic [CW-1:0] cand_cnt,
    input  logic          cand_act,
    output slot_t         min1,
    output slot_t         min2
);

    logic [CW-1:0] min1_cnt;
    logic [CW-1:0] min2_cnt;
    logic          beats1;
    logic          beats2;

    // Lower count ranks smaller; on a tie the higher slot index ranks smaller.
    function automatic logic ranks_before(input logic [CW-1:0] ca, input slot_t ia,
                                          input logic [CW-1:0] cb, input slot_t ib);
        return (ca < cb) || ((ca == cb) && (ia > ib));
    endfunction

    // Compare the candidate against both current minima.
    always_comb begin
        beats1 = (min1 == NIL_SLOT) || ranks_before(cand_cnt, cand_idx, min1_cnt, min1);
        beats2 = (min2 == NIL_SLOT) || ranks_before(cand_cnt, cand_idx, min2_cnt, min2);
    end

    // Insert an active candidate into the ordered pair {min1, min2}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min1     <= NIL_SLOT;
            min2     <= NIL_SLOT;
            min1_cnt <= '0;
            min2_cnt <= '0;
        end else if (start) begin
            min1     <= NIL_SLOT;
            min2     <= NIL_SLOT;
            min1_cnt <= '0;
            min2_cnt <= '0;
        end else if (step && cand_act) begin
            if (beats1) begin
                min2     <= min1;
                min2_cnt <= min1_cnt;
                min1     <= cand_idx;
                min1_cnt <= cand_cnt;
            end else if (beats2) begin
                min2     <= cand_idx;
                min2_cnt <= cand_cnt;
            end
        end
    end

endmodule

// File: rtl/huffman_param.sv
// rtl/huffman_param.sv - per-frame histogram and Huffman code builder
module huffman_param
    import huffman_pkg::*;
#(
    parameter int NSYM   = 6,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_valid,
    input  logic [DATA_W-1:0]      gray_data,
    input  logic                   gray_last,
    output logic                   gray_ready,
    output logic                   cnt_valid,
    output logic [NSYM*CNT_W-1:0]  cnt,
    output logic                   code_valid,
    input  logic                   code_ack,
    output logic [NSYM*CODE_W-1:0] hc,
    output logic [NSYM*CODE_W-1:0] m,
    output logic [2:0]             err
);

    localparam int   NNODE      = 2*NSYM - 1;
    localparam int   AW         = $clog2(NNODE);
    localparam int   NW         = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam slot_t LAST_SLOT  = slot_t'(NNODE - 1);
    localparam slot_t FIRST_NODE = slot_t'(NSYM);

    logic [2:0]        state;
    logic [CNT_W-1:0]  hist      [NSYM];
    slot_t             node_par  [NNODE];
    logic              node_left [NNODE];
    logic [NW-1:0]     node_cnt  [NNODE];
    logic              node_act  [NNODE];
    slot_t             n_active;
    slot_t             merge_slot;
    slot_t             scan_idx;
    slot_t             walk_pos  [NSYM];
    slot_t             walk_dep  [NSYM];
    logic [CODE_W-1:0] hc_r      [NSYM];
    logic [CODE_W-1:0] m_r       [NSYM];
    logic [2:0]        err_r;

    logic              accept;
    logic              sym_ok;
    slot_t             leaf_cnt;
    slot_t             walk_par  [NSYM];
    logic              walk_bit  [NSYM];
    logic              walk_done;
    slot_t             min1;
    slot_t             min2;
    logic              merge_ok;
    logic [NW-1:0]     merge_sum;
    logic [NW-1:0]     cand_cnt;
    logic              cand_act;

    assign gray_ready = (state == ST_COLLECT);
    assign cnt_valid  = (state == ST_HIST);
    assign code_valid = (state == ST_DONE);
    assign err        = err_r;
    assign accept     = gray_valid && (state == ST_COLLECT);
    assign sym_ok     = (gray_data != '0) && (gray_data <= DATA_W'(NSYM));

    // Pack per-symbol registers onto the flat output buses.
    always_comb begin
        cnt = '0;
        hc  = '0;
        m   = '0;
        for (int s = 0; s < NSYM; s++) begin
            cnt[s*CNT_W +: CNT_W]  = hist[s];
            hc[s*CODE_W +: CODE_W] = hc_r[s];
            m[s*CODE_W +: CODE_W]  = m_r[s];
        end
    end

    // Number of symbols present in the frame.
    always_comb begin
        leaf_cnt = '0;
        for (int s = 0; s < NSYM; s++) begin
            if (hist[s] != '0) leaf_cnt = leaf_cnt + slot_t'(1);
        end
    end

    // Candidate slot presented to the min-2 scanner.
    always_comb begin
        cand_cnt = '0;
        cand_act = 1'b0;
        if (scan_idx <= LAST_SLOT) begin
            cand_cnt = node_cnt[scan_idx[AW-1:0]];
            cand_act = node_act[scan_idx[AW-1:0]];
        end
    end

    // Sum of the two chosen children for the node being created.
    always_comb begin
        merge_ok  = (min1 != NIL_SLOT) && (min2 != NIL_SLOT);
        merge_sum = '0;
        if (merge_ok) merge_sum = node_cnt[min1[AW-1:0]] + node_cnt[min2[AW-1:0]];
    end

    // Each leaf's current ancestor, the branch bit taken there, and walk completion.
    always_comb begin
        walk_done = 1'b1;
        for (int s = 0; s < NSYM; s++) begin
            walk_par[s] = NIL_SLOT;
            walk_bit[s] = 1'b0;
            if (walk_pos[s] <= LAST_SLOT) begin
                walk_par[s] = node_par[walk_pos[s][AW-1:0]];
                walk_bit[s] = node_left[walk_pos[s][AW-1:0]];
            end
            if (walk_par[s] != NIL_SLOT) walk_done = 1'b0;
        end
    end

    huffman_min2_scan #(
        .CW (NW)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .start    ((state == ST_HIST) || (state == ST_MERGE)),
        .step     (state == ST_SCAN),
        .cand_idx (scan_idx),
        .cand_cnt (cand_cnt),
        .cand_act (cand_act),
        .min1     (min1),
        .min2     (min2)
    );

    // Frame FSM: histogram, tree build, leaf-to-root walk, result hand-off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_COLLECT;
            err_r      <= '0;
            n_active   <= '0;
            merge_slot <= FIRST_NODE;
            scan_idx   <= '0;
            for (int s = 0; s < NSYM; s++) begin
                hist[s]     <= '0;
                walk_pos[s] <= slot_t'(s);
                walk_dep[s] <= '0;
                hc_r[s]     <= '0;
                m_r[s]      <= '0;
            end
            for (int i = 0; i < NNODE; i++) begin
                node_par[i]  <= NIL_SLOT;
                node_left[i] <= 1'b0;
                node_cnt[i]  <= '0;
                node_act[i]  <= 1'b0;
            end
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        if (!sym_ok) err_r[ERR_BAD_SYM] <= 1'b1;
                        for (int s = 0; s < NSYM; s++) begin
                            if (gray_data == DATA_W'(s + 1)) begin
                                if (hist[s] == CNT_MAX) err_r[ERR_CNT_SAT] <= 1'b1;
                                else                    hist[s] <= hist[s] + CNT_W'(1);
                            end
                        end
                        if (gray_last) state <= ST_HIST;
                    end
                end
                ST_HIST: begin
                    for (int s = 0; s < NSYM; s++) begin
                        node_cnt[s]  <= NW'(hist[s]);
                        node_act[s]  <= (hist[s] != '0);
                        node_par[s]  <= NIL_SLOT;
                        node_left[s] <= 1'b0;
                        walk_pos[s]  <= slot_t'(s);
                        walk_dep[s]  <= '0;
                        // A lone symbol gets a one-bit code of 0.
                        if ((leaf_cnt == slot_t'(1)) && (hist[s] != '0)) m_r[s] <= CODE_W'(1);
                    end
                    for (int i = NSYM; i < NNODE; i++) begin
                        node_par[i]  <= NIL_SLOT;
                        node_left[i] <= 1'b0;
                        node_cnt[i]  <= '0;
                        node_act[i]  <= 1'b0;
                    end
                    n_active   <= leaf_cnt;
                    merge_slot <= FIRST_NODE;
                    scan_idx   <= '0;
                    state      <= (leaf_cnt < slot_t'(2)) ? ST_DONE : ST_SCAN;
                end
                ST_SCAN: begin
                    if (scan_idx == LAST_SLOT) begin
                        scan_idx <= '0;
                        state    <= ST_MERGE;
                    end else begin
                        scan_idx <= scan_idx + slot_t'(1);
                    end
                end
                ST_MERGE: begin
                    if (merge_ok) begin
                        node_par[min1[AW-1:0]]       <= merge_slot;
                        node_left[min1[AW-1:0]]      <= 1'b1;
                        node_act[min1[AW-1:0]]       <= 1'b0;
                        node_par[min2[AW-1:0]]       <= merge_slot;
                        node_left[min2[AW-1:0]]      <= 1'b0;
                        node_act[min2[AW-1:0]]       <= 1'b0;
                        node_cnt[merge_slot[AW-1:0]] <= merge_sum;
                        node_act[merge_slot[AW-1:0]] <= 1'b1;
                    end
                    merge_slot <= merge_slot + slot_t'(1);
                    n_active   <= n_active - slot_t'(1);
                    state      <= (n_active > slot_t'(2)) ? ST_SCAN : ST_WALK;
                end
                ST_WALK: begin
                    if (walk_done) begin
                        state <= ST_DONE;
                    end else begin
                        for (int s = 0; s < NSYM; s++) begin
                            if (walk_par[s] != NIL_SLOT) begin
                                for (int b = 0; b < CODE_W; b++) begin
                                    if (int'(walk_dep[s]) == b) hc_r[s][b] <= walk_bit[s];
                                end
                                if (int'(walk_dep[s]) >= CODE_W) err_r[ERR_CODE_OVF] <= 1'b1;
                                m_r[s]      <= {m_r[s][CODE_W-2:0], 1'b1};
                                walk_pos[s] <= walk_par[s];
                                walk_dep[s] <= walk_dep[s] + slot_t'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (code_ack) begin
                        err_r <= '0;
                        for (int s = 0; s < NSYM; s++) begin
                            hist[s] <= '0;
                            hc_r[s] <= '0;
                            m_r[s]  <= '0;
                        end
                        state <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_param.sv
// tb/tb_huffman_param.sv - directed self-checking bench for huffman_param
module tb_huffman_param;

    localparam int NSYM   = 6;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int CODE_W = 8;

    localparam logic [47:0] CNT1 = 48'h0000_0101_0204;
    localparam logic [47:0] HC1  = 48'h0000_0706_0200;
    localparam logic [47:0] M1   = 48'h0000_0707_0301;

    logic                   clk;
    logic                   reset;
    logic                   gray_valid;
    logic [DATA_W-1:0]      gray_data;
    logic                   gray_last;
    logic                   gray_ready;
    logic                   cnt_valid;
    logic [NSYM*CNT_W-1:0]  cnt;
    logic                   code_valid;
    logic                   code_ack;
    logic [NSYM*CODE_W-1:0] hc;
    logic [NSYM*CODE_W-1:0] m;
    logic [2:0]             err;

    int checks = 0;
    int errors = 0;
    int frame_q[$];
    int lat;
    int ready_seen;

    huffman_param #(
        .NSYM   (NSYM),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .CODE_W (CODE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .gray_last  (gray_last),
        .gray_ready (gray_ready),
        .cnt_valid  (cnt_valid),
        .cnt        (cnt),
        .code_valid (code_valid),
        .code_ack   (code_ack),
        .hc         (hc),
        .m          (m),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic play_frame();
        for (int i = 0; i < frame_q.size(); i++) begin
            gray_valid = 1'b1;
            gray_data  = DATA_W'(frame_q[i]);
            gray_last  = (i == frame_q.size() - 1);
            tick();
        end
        gray_valid = 1'b0;
        gray_last  = 1'b0;
        gray_data  = '0;
    endtask

    task automatic wait_code(output int n);
        n = 1;
        while (!code_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_ack();
        code_ack = 1'b1;
        tick();
        code_ack = 1'b0;
    endtask

    task automatic frame_t1(input string tag, input bit with_bad);
        int n;
        if (with_bad) frame_q = '{1, 0, 2, 1, 7, 3, 1, 2, 4, 1};
        else          frame_q = '{1, 2, 1, 3, 1, 2, 4, 1};
        play_frame();
        check({tag, "_cnt_valid"}, cnt_valid, 1);
        check({tag, "_cnt"}, cnt, CNT1);
        wait_code(n);
        check({tag, "_latency"}, n, 42);
        check({tag, "_hc"}, hc, HC1);
        check({tag, "_m"}, m, M1);
        check({tag, "_err"}, err, with_bad ? 3'b001 : 3'b000);
    endtask

    initial begin
        reset      = 1'b0;
        gray_valid = 1'b0;
        gray_data  = '0;
        gray_last  = 1'b0;
        code_ack   = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        check("rst_ready", gray_ready, 1);
        check("rst_cnt_valid", cnt_valid, 0);
        check("rst_code_valid", code_valid, 0);
        check("rst_cnt", cnt, 0);
        check("rst_m", m, 0);
        check("rst_err", err, 0);

        // 1: mixed counts 4,2,1,1,0,0
        frame_t1("t1", 1'b0);
        do_ack();
        check("t1_ack_ready", gray_ready, 1);
        check("t1_ack_cv", code_valid, 0);
        check("t1_ack_cnt", cnt, 0);
        check("t1_ack_m", m, 0);

        // 2: single symbol present
        frame_q = '{2, 2, 2, 2, 2};
        play_frame();
        check("t2_cnt", cnt, 48'h0000_0000_0500);
        wait_code(lat);
        check("t2_latency", lat, 2);
        check("t2_hc", hc, 0);
        check("t2_m", m, 48'h0000_0000_0100);
        check("t2_err", err, 0);
        do_ack();

        // 3: saturating s1 plus a single s3
        frame_q.delete();
        for (int i = 0; i < 300; i++) frame_q.push_back(1);
        frame_q.push_back(3);
        play_frame();
        check("t3_cnt", cnt, 48'h0000_0001_00FF);
        wait_code(lat);
        check("t3_latency", lat, 16);
        check("t3_hc", hc, 48'h0000_0001_0000);
        check("t3_m", m, 48'h0000_0001_0001);
        check("t3_err", err, 3'b010);
        do_ack();

        // 4: test 1 frame with out-of-range symbols mixed in
        frame_t1("t4", 1'b1);

        // 5: delayed ack, samples offered while waiting are ignored
        ready_seen = 0;
        for (int i = 0; i < 20; i++) begin
            gray_valid = i[0];
            gray_data  = 8'd1;
            gray_last  = i[0];
            tick();
            if (gray_ready) ready_seen++;
        end
        gray_valid = 1'b0;
        gray_last  = 1'b0;
        gray_data  = '0;
        check("t5_ready_seen", ready_seen, 0);
        check("t5_cv", code_valid, 1);
        check("t5_hc", hc, HC1);
        check("t5_m", m, M1);
        check("t5_cnt", cnt, CNT1);
        check("t5_err", err, 3'b001);
        do_ack();
        check("t5_ack_cnt", cnt, 0);
        frame_q = '{5, 5, 5, 6};
        play_frame();
        check("t5_next_cnt", cnt, 48'h0103_0000_0000);
        wait_code(lat);
        check("t5_next_hc", hc, 48'h0100_0000_0000);
        check("t5_next_m", m, 48'h0101_0000_0000);
        do_ack();

        // 6: reset during SCAN, then repeat test 1
        frame_q = '{1, 2, 1, 3, 1, 2, 4, 1};
        play_frame();
        repeat (4) tick();
        check("t6_pre_cnt", cnt, CNT1);
        check("t6_pre_ready", gray_ready, 0);
        reset = 1'b0;
        #1;
        check("t6_rst_ready", gray_ready, 1);
        check("t6_rst_cnt", cnt, 0);
        check("t6_rst_cv", code_valid, 0);
        check("t6_rst_cnt_valid", cnt_valid, 0);
        check("t6_rst_hc", hc, 0);
        check("t6_rst_m", m, 0);
        check("t6_rst_err", err, 0);
        tick();
        reset = 1'b1;
        tick();
        frame_t1("t6", 1'b0);
        do_ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
